mdu_ctrl: RTL and testbench

Multiply/divide unit controller for the MIPS32 core. It owns the architectural HI and LO registers and accepts decoded mult/multu/div/divu/mthi/mtlo/mfhi/mflo commands from the decode-stage control signals. It runs a fixed-latency multiply and an iterative radix-2 divide, and raises a pipeline stall whenever an instruction touches HI/LO while an operation is in flight.

---
 rtl/mdu_pkg.sv | 25 ++
 rtl/div_radix2.sv | 24 ++
 rtl/mdu_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_mdu_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared types and constants for the multiply/divide unit.
// Holds the FSM state encoding, widths and a small abs helper.
package mdu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } mdu_state_t;

    localparam int DIV_STEPS = 32;
    localparam int PROD_W    = 64;
    localparam int REM_W     = 64;
    localparam int CNT_W     = 5;

    // Magnitude of v when treated as signed, raw value otherwise.
    function automatic logic [31:0] abs32(
        input logic [31:0] v,
        input logic        sgn
    );
        return (sgn && v[31]) ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/div_radix2.sv
// One combinational restoring-division step.
// Ports: rem_in/rem_out {remainder, dividend/quotient}, divisor, q_bit.
module div_radix2
    import mdu_pkg::*;
(
    input  logic [REM_W-1:0] rem_in,
    input  logic [31:0]      divisor,
    output logic [REM_W-1:0] rem_out,
    output logic             q_bit
);

    // 2R + next dividend bit can need 33 bits when divisor > 2^31.
    logic [32:0] top;
    logic [31:0] r_next;

    always_comb begin
        top     = rem_in[63:31];
        q_bit   = (top >= {1'b0, divisor});
        // On subtract the result is < divisor, so 32 bits suffice.
        r_next  = q_bit ? (top[31:0] - divisor) : top[31:0];
        rem_out = {r_next, rem_in[30:0], q_bit};
    end

endmodule

// File: rtl/mdu_ctrl.sv
// MIPS32 multiply/divide controller owning the HI/LO registers.
// Ports: clk, reset, decoded commands + rs/rt data in; hi, lo, busy, stall out.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    input  logic        is_mult,
    input  logic        is_multu,
    input  logic        is_div,
    input  logic        is_divu,
    input  logic        hi_wen,
    input  logic        lo_wen,
    input  logic        is_result_hi,
    input  logic        is_result_lo,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall
);

    localparam logic [CNT_W-1:0] MUL_CNT0 = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_CNT0 = CNT_W'(DIV_STEPS - 1);

    mdu_state_t state_q;
    mdu_state_t state_d;

    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      op_a_q;
    logic [31:0]      op_b_q;
    logic             sgn_q;
    logic             q_neg_q;
    logic             r_neg_q;
    logic [REM_W-1:0] rem_q;
    logic [REM_W-1:0] rem_step;
    logic             q_bit_unused;

    logic idle;
    logic any_op;
    logic touch;
    logic accept;
    logic start_mul;
    logic start_div;

    logic signed [63:0] mul_a;
    logic signed [63:0] mul_b;
    logic [PROD_W-1:0]  prod;
    logic [PROD_W-1:0]  mul_res;

    assign idle   = (state_q == ST_IDLE);
    assign any_op = is_mult | is_multu | is_div | is_divu;
    assign touch  = any_op | hi_wen | lo_wen
                  | is_result_hi | is_result_lo;
    assign accept = cmd_valid & idle;

    assign start_mul = accept & (is_mult | is_multu);
    // Divide by zero is dropped: no state change, no busy cycle.
    assign start_div = accept & (is_div | is_divu)
                     & (rt_data != 32'd0);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                unique case (1'b1)
                    start_mul: state_d = ST_MUL;
                    start_div: state_d = ST_DIV;
                    default:   state_d = ST_IDLE;
                endcase
            end
            ST_MUL: begin
                if (cnt_q == '0) state_d = ST_IDLE;
            end
            ST_DIV: begin
                if (cnt_q == '0) state_d = ST_FIX;
            end
            ST_FIX:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        busy  = !idle;
        stall = busy & cmd_valid & touch;
    end

    // Multiply: sign/zero-extend to 64 bits, low 64 bits are exact.
    always_comb begin
        mul_a = {{32{sgn_q & op_a_q[31]}}, op_a_q};
        mul_b = {{32{sgn_q & op_b_q[31]}}, op_b_q};
        prod  = mul_a * mul_b;
    end

    generate
        if (MUL_LAT <= 1) begin : g_mul_comb
            assign mul_res = prod;
        end else begin : g_mul_pipe
            // Reset-free so synthesis can retime into DSP registers.
            logic [PROD_W-1:0] pipe_q [MUL_LAT-1];
            always_ff @(posedge clk) begin
                pipe_q[0] <= prod;
                for (int i = 1; i < MUL_LAT - 1; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
            assign mul_res = pipe_q[MUL_LAT-2];
        end
    endgenerate

    div_radix2 u_div (
        .rem_in  (rem_q),
        .divisor (op_b_q),
        .rem_out (rem_step),
        .q_bit   (q_bit_unused)
    );

    // Datapath and HI/LO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            sgn_q   <= 1'b0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            rem_q   <= '0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    unique case (1'b1)
                        start_mul: begin
                            op_a_q <= rs_data;
                            op_b_q <= rt_data;
                            sgn_q  <= is_mult;
                            cnt_q  <= MUL_CNT0;
                        end
                        start_div: begin
                            op_b_q  <= abs32(rt_data, is_div);
                            rem_q   <= {32'd0, abs32(rs_data, is_div)};
                            q_neg_q <= is_div & (rs_data[31] ^ rt_data[31]);
                            r_neg_q <= is_div & rs_data[31];
                            cnt_q   <= DIV_CNT0;
                        end
                        default: ;
                    endcase
                    if (accept && hi_wen) hi <= rs_data;
                    if (accept && lo_wen) lo <= rs_data;
                end
                ST_MUL: begin
                    if (cnt_q == '0) begin
                        hi <= mul_res[63:32];
                        lo <= mul_res[31:0];
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_DIV: begin
                    rem_q <= rem_step;
                    if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
                end
                ST_FIX: begin
                    lo <= q_neg_q ? (32'd0 - rem_q[31:0]) : rem_q[31:0];
                    hi <= r_neg_q ? (32'd0 - rem_q[63:32]) : rem_q[63:32];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl.
// Table of directed ops plus hand sequences for reset, stall and back-to-back.
module tb_mdu_ctrl;

    localparam int MUL_LAT = 2;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        is_mult;
    logic        is_multu;
    logic        is_div;
    logic        is_divu;
    logic        hi_wen;
    logic        lo_wen;
    logic        is_result_hi;
    logic        is_result_lo;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        stall;

    int checks;
    int errors;

    mdu_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .is_mult      (is_mult),
        .is_multu     (is_multu),
        .is_div       (is_div),
        .is_divu      (is_divu),
        .hi_wen       (hi_wen),
        .lo_wen       (lo_wen),
        .is_result_hi (is_result_hi),
        .is_result_lo (is_result_lo),
        .rs_data      (rs_data),
        .rt_data      (rt_data),
        .hi           (hi),
        .lo           (lo),
        .busy         (busy),
        .stall        (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    typedef enum int {
        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO, OP_MFLO
    } op_e;

    typedef struct {
        op_e         op;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [31:0] hi;
        logic [31:0] lo;
        int          cyc;
    } vec_t;

    vec_t vt [15];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_cmd();
        cmd_valid    = 1'b0;
        is_mult      = 1'b0;
        is_multu     = 1'b0;
        is_div       = 1'b0;
        is_divu      = 1'b0;
        hi_wen       = 1'b0;
        lo_wen       = 1'b0;
        is_result_hi = 1'b0;
        is_result_lo = 1'b0;
        rs_data      = 32'd0;
        rt_data      = 32'd0;
    endtask

    task automatic set_cmd(input op_e op, input logic [31:0] a,
                           input logic [31:0] b);
        clear_cmd();
        cmd_valid = 1'b1;
        rs_data   = a;
        rt_data   = b;
        case (op)
            OP_MULT:  is_mult      = 1'b1;
            OP_MULTU: is_multu     = 1'b1;
            OP_DIV:   is_div       = 1'b1;
            OP_DIVU:  is_divu      = 1'b1;
            OP_MTHI:  hi_wen       = 1'b1;
            OP_MTLO:  lo_wen       = 1'b1;
            default:  is_result_lo = 1'b1;
        endcase
    endtask

    // Issue at a negedge, then count busy cycles until done.
    task automatic run_op(input op_e op, input logic [31:0] a,
                          input logic [31:0] b, output int cyc);
        set_cmd(op, a, b);
        @(posedge clk);
        @(negedge clk);
        clear_cmd();
        cyc = 0;
        while (busy && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    initial begin
        int cyc;
        int n;
        int stall_bad;

        checks = 0;
        errors = 0;
        clear_cmd();

        vt[0]  = '{OP_MULT,  32'd3,        32'd4,        32'h0,        32'd12,       MUL_LAT};
        vt[1]  = '{OP_MULT,  32'hFFFFFFFF, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT};
        vt[2]  = '{OP_MULTU, 32'hFFFFFFFF, 32'h2,        32'h1,        32'hFFFFFFFE, MUL_LAT};
        vt[3]  = '{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h0,        MUL_LAT};
        vt[4]  = '{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1,        MUL_LAT};
        vt[5]  = '{OP_DIV,   32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33};
        vt[6]  = '{OP_DIVU,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0,        33};
        vt[7]  = '{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 33};
        vt[8]  = '{OP_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       33};
        vt[9]  = '{OP_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 33};
        vt[10] = '{OP_DIVU,  32'hFFFFFFFF, 32'h1,        32'h0,        32'hFFFFFFFF, 33};
        vt[11] = '{OP_MTHI,  32'h11,       32'h0,        32'h11,       32'hFFFFFFFF, 0};
        vt[12] = '{OP_MTLO,  32'h22,       32'h0,        32'h11,       32'h22,       0};
        vt[13] = '{OP_DIV,   32'd5,        32'h0,        32'h11,       32'h22,       0};
        vt[14] = '{OP_DIVU,  32'd5,        32'h0,        32'h11,       32'h22,       0};

        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        cmd_valid    = 1'b1;
        is_result_lo = 1'b1;
        #1;
        chk("rst_hi", hi, 32'h0);
        chk("rst_lo", lo, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("idle_mflo_stall", {31'd0, stall}, 32'd0);
        clear_cmd();
        @(negedge clk);

        for (int i = 0; i < 15; i++) begin
            run_op(vt[i].op, vt[i].rs, vt[i].rt, cyc);
            chk($sformatf("v%0d_hi", i), hi, vt[i].hi);
            chk($sformatf("v%0d_lo", i), lo, vt[i].lo);
            chk($sformatf("v%0d_busy", i), cyc, vt[i].cyc);
        end

        // Reset around cycle 10 of a divide
        set_cmd(OP_DIVU, 32'd100, 32'd7);
        @(posedge clk);
        @(negedge clk);
        clear_cmd();
        repeat (9) @(negedge clk);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_hi", hi, 32'h0);
        chk("midrst_lo", lo, 32'h0);
        repeat (40) @(negedge clk);
        chk("midrst_late_lo", lo, 32'h0);
        chk("midrst_late_busy", {31'd0, busy}, 32'd0);
        run_op(OP_MULT, 32'd3, 32'd4, cyc);
        chk("post_rst_lo", lo, 32'd12);
        chk("post_rst_hi", hi, 32'd0);
        chk("post_rst_busy", cyc, MUL_LAT);

        // mflo presented on cycle 5 of a divide
        set_cmd(OP_DIVU, 32'd100, 32'd7);
        @(posedge clk);
        @(negedge clk);
        clear_cmd();
        repeat (4) @(negedge clk);
        set_cmd(OP_MFLO, 32'd0, 32'd0);
        #1;
        n = 0;
        stall_bad = 0;
        while (busy && n < 100) begin
            if (stall !== 1'b1) stall_bad++;
            if (n == 3) begin
                is_result_lo = 1'b0;
                #1;
                chk("addu_stall", {31'd0, stall}, 32'd0);
                is_result_lo = 1'b1;
                #1;
            end
            @(negedge clk);
            #1;
            n++;
        end
        chk("mflo_stall_cycles", n, 29);
        chk("mflo_stall_bad", stall_bad, 0);
        chk("mflo_stall_low", {31'd0, stall}, 32'd0);
        chk("mflo_quot", lo, 32'd14);
        chk("mflo_rem", hi, 32'd2);
        @(negedge clk);
        clear_cmd();

        // mtlo immediately followed by mflo
        set_cmd(OP_MTLO, 32'hDEADBEEF, 32'd0);
        @(posedge clk);
        @(negedge clk);
        set_cmd(OP_MFLO, 32'd0, 32'd0);
        #1;
        chk("mtlo_mflo_lo", lo, 32'hDEADBEEF);
        chk("mtlo_mflo_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);
        clear_cmd();

        // Back-to-back multiplies with the second held while busy
        set_cmd(OP_MULT, 32'd5, 32'd6);
        @(posedge clk);
        @(negedge clk);
        set_cmd(OP_MULT, 32'd7, 32'd8);
        #1;
        n = 0;
        stall_bad = 0;
        while (busy && n < 50) begin
            if (stall !== 1'b1) stall_bad++;
            n++;
            @(negedge clk);
            #1;
        end
        chk("b2b_first_cyc", n, MUL_LAT);
        chk("b2b_stall_bad", stall_bad, 0);
        chk("b2b_first_lo", lo, 32'd30);
        chk("b2b_stall_free", {31'd0, stall}, 32'd0);
        @(negedge clk);
        clear_cmd();
        chk("b2b_accept", {31'd0, busy}, 32'd1);
        n = 0;
        while (busy && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("b2b_second_cyc", n, MUL_LAT);
        chk("b2b_second_lo", lo, 32'd56);
        chk("b2b_second_hi", hi, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
